gearbox_128b130b_tx: RTL and testbench

Parametrised 128b/130b transmit framer/gearbox for the PCIe 3.0 logical Tx path. It sits between the scrambler and the lane serializer. It accepts DATA_W-bit scrambled words, prepends a 2-bit sync header to every 128-bit block, and repacks the 130-bit stream into DATA_W-bit output words. The input is back-pressured so the output stays dense. A bypass mode passes words through unframed for Gen1/2 (8b/10b) operation.

---
 rtl/gearbox_128b130b_tx_if.sv | 28 ++
 rtl/gearbox_128b130b_tx.sv | 136 +++++++++++++
 tb/tb_gearbox_128b130b_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gearbox_128b130b_tx_if.sv
// Payload handshake, framed output and status bundle of the 128b/130b Tx gearbox.
// The producer/serializer side uses master; the gearbox uses slave.
interface gearbox_128b130b_tx_if #(
  parameter int DATA_W = 8
);
  localparam int WPB   = 128 / DATA_W;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

  logic              bypass;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_k;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  word_idx;
  logic              blk_err;

  modport master (
    output bypass, in_valid, in_data, in_k,
    input  in_ready, out_valid, out_data, word_idx, blk_err
  );

  modport slave (
    input  bypass, in_valid, in_data, in_k,
    output in_ready, out_valid, out_data, word_idx, blk_err
  );
endinterface

// File: rtl/gearbox_128b130b_tx.sv
// 128b/130b transmit framer: prepends a 2-bit sync header to every 128-bit block and
// repacks the 130-bit stream into DATA_W-bit words; bypass passes words through unframed.
module gearbox_128b130b_tx #(
  parameter int DATA_W = 8
) (
  input  logic                 clk_8G,
  input  logic                 rst_8G,
  gearbox_128b130b_tx_if.slave gb
);

  localparam int WPB   = 128 / DATA_W;
  localparam int BUF_W = 2 * DATA_W + 2;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  // One spare bit so occ + need never wraps before the capacity compare.
  localparam int OCC_W = $clog2(BUF_W + 1) + 1;

  typedef enum logic {
    MODE_FRAME  = 1'b0,
    MODE_BYPASS = 1'b1
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              blk_err_q, blk_err_d;

  logic              mode_chg;
  logic              blk_start;
  logic              drain;
  logic              fits;
  logic              in_ready;
  logic              accept;
  logic [1:0]        hdr;
  logic [OCC_W-1:0]  occ_left;
  logic [OCC_W-1:0]  need;
  logic [BUF_W-1:0]  buf_left;
  logic [BUF_W-1:0]  ins;

  // Handshake and datapath terms shared by both modes.
  always_comb begin
    mode_d    = gb.bypass ? MODE_BYPASS : MODE_FRAME;
    mode_chg  = (mode_d != mode_q);
    blk_start = (widx_q == '0);
    drain     = (occ_q >= OCC_W'(DATA_W));
    occ_left  = drain ? (occ_q - OCC_W'(DATA_W)) : occ_q;
    buf_left  = drain ? (buf_q >> DATA_W) : buf_q;
    need      = blk_start ? OCC_W'(DATA_W + 2) : OCC_W'(DATA_W);
    fits      = ((occ_left + need) <= OCC_W'(BUF_W));

    // The mode-change cycle flushes the buffer, so no word is taken in that cycle.
    if (rst_8G || mode_chg) begin
      in_ready = 1'b0;
    end else if (gb.bypass) begin
      in_ready = 1'b1;
    end else begin
      in_ready = fits;
    end

    accept = gb.in_valid && in_ready;
    hdr    = gb.in_k ? 2'b01 : 2'b10;
    ins    = blk_start ? BUF_W'({gb.in_data, hdr}) : BUF_W'(gb.in_data);
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    buf_d       = buf_q;
    occ_d       = occ_q;
    widx_d      = widx_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    blk_err_d   = 1'b0;

    if (mode_chg) begin
      buf_d     = '0;
      occ_d     = '0;
      widx_d    = '0;
      blk_err_d = (occ_q != '0) || !blk_start;
    end else if (gb.bypass) begin
      buf_d       = '0;
      occ_d       = '0;
      widx_d      = '0;
      out_data_d  = gb.in_data;
      out_valid_d = gb.in_valid;
    end else begin
      blk_err_d = !blk_start && in_ready && !gb.in_valid;

      if (drain) begin
        out_data_d  = buf_q[DATA_W-1:0];
        out_valid_d = 1'b1;
      end

      buf_d = buf_left;
      occ_d = occ_left;

      // New bits land directly above whatever survives this cycle's drain.
      if (accept) begin
        buf_d  = buf_left | (ins << occ_left);
        occ_d  = occ_left + need;
        widx_d = (widx_q == IDX_W'(WPB - 1)) ? '0 : widx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_8G or posedge rst_8G) begin
    if (rst_8G) begin
      mode_q      <= MODE_FRAME;
      buf_q       <= '0;
      occ_q       <= '0;
      widx_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      blk_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values
      // computed above, independent of statement order.
      mode_q      <= mode_d;
      buf_q       <= buf_d;
      occ_q       <= occ_d;
      widx_q      <= widx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      blk_err_q   <= blk_err_d;
    end
  end

  assign gb.in_ready  = in_ready;
  assign gb.out_valid = out_valid_q;
  assign gb.out_data  = out_data_q;
  assign gb.word_idx  = widx_q;
  assign gb.blk_err   = blk_err_q;

endmodule

// File: tb/tb_gearbox_128b130b_tx.sv
// Bench for gearbox_128b130b_tx: header vector table, then scoreboarded sequences for
// continuous flow, underrun, bypass entry/exit and mid-block reset.
module tb_gearbox_128b130b_tx;

  localparam int DATA_W = 8;
  localparam int WPB    = 128 / DATA_W;

  logic clk_8G = 1'b0;
  logic rst_8G = 1'b0;

  gearbox_128b130b_tx_if #(.DATA_W(DATA_W)) gb ();

  gearbox_128b130b_tx #(.DATA_W(DATA_W)) dut (
    .clk_8G (clk_8G),
    .rst_8G (rst_8G),
    .gb     (gb)
  );

  always #5 clk_8G = ~clk_8G;

  typedef struct {
    bit                rst;
    logic              v;
    logic [DATA_W-1:0] d;
    logic              k;
    logic              byp;
    logic              exp_ov;
    logic [DATA_W-1:0] exp_od;
  } vec_t;

  vec_t tbl[$];

  int total = 0;
  int bad   = 0;

  bit                exp_q[$];
  int                widx_m;
  bit                byp_m;
  int                acc_cnt;
  int                err_cnt;
  int                stall_q[$];
  logic              last_ov;
  logic [DATA_W-1:0] last_od;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void add_vec(input bit rst, input logic v, input logic [DATA_W-1:0] d,
                                  input logic k, input logic byp, input logic ov,
                                  input logic [DATA_W-1:0] od);
    vec_t e;
    e.rst = rst; e.v = v; e.d = d; e.k = k; e.byp = byp; e.exp_ov = ov; e.exp_od = od;
    tbl.push_back(e);
  endfunction

  // Starts and ends on a falling edge; asserts reset between edges and checks outputs at once.
  task automatic apply_reset();
    gb.in_valid = 1'b0;
    gb.in_data  = '0;
    gb.in_k     = 1'b0;
    gb.bypass   = 1'b0;
    rst_8G      = 1'b0;
    #1 rst_8G   = 1'b1;
    #2;
    check("rst_out_valid", gb.out_valid, 0);
    check("rst_out_data",  gb.out_data, 0);
    check("rst_blk_err",   gb.blk_err, 0);
    check("rst_word_idx",  gb.word_idx, 0);
    check("rst_in_ready",  gb.in_ready, 0);
    @(negedge clk_8G);
    rst_8G = 1'b0;
    exp_q.delete();
    widx_m = 0;
    byp_m  = 1'b0;
  endtask

  // One clock: drive at the falling edge, record acceptance, observe at the next falling edge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic k, input logic byp);
    logic              rdy;
    logic [1:0]        hdr;
    logic [DATA_W-1:0] e;
    gb.in_valid = v;
    gb.in_data  = d;
    gb.in_k     = k;
    gb.bypass   = byp;
    #1;
    rdy = gb.in_ready;
    if (byp != byp_m) begin
      exp_q.delete();
      widx_m = 0;
      byp_m  = byp;
    end
    if (v && !rdy && !byp) stall_q.push_back(acc_cnt);
    if (v && rdy) begin
      acc_cnt++;
      if (!byp && widx_m == 0) begin
        hdr = k ? 2'b01 : 2'b10;
        exp_q.push_back(hdr[0]);
        exp_q.push_back(hdr[1]);
      end
      for (int i = 0; i < DATA_W; i++) exp_q.push_back(d[i]);
      if (!byp) widx_m = (widx_m + 1) % WPB;
    end
    @(negedge clk_8G);
    last_ov = gb.out_valid;
    last_od = gb.out_data;
    if (gb.blk_err === 1'b1) err_cnt++;
    if (gb.out_valid === 1'b1) begin
      if (exp_q.size() < DATA_W) begin
        check("sb_underflow", exp_q.size(), DATA_W);
      end else begin
        for (int i = 0; i < DATA_W; i++) e[i] = exp_q.pop_front();
        check("sb_out_data", gb.out_data, e);
      end
    end
    check("word_idx", gb.word_idx, widx_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int                exp_stall[3];
    int                gaps;
    bit                seen;
    logic [DATA_W-1:0] d;

    exp_stall = '{80, 144, 208};
    acc_cnt = 0;
    err_cnt = 0;

    // Header vectors. Group A: data header 10 over 8'hFF.
    add_vec(1, 1, 8'hFF, 0, 0, 0, 8'h00);
    add_vec(0, 1, 8'hFF, 0, 0, 1, 8'hFE);
    for (int i = 0; i < 4; i++) add_vec(0, 1, 8'hFF, 0, 0, 1, 8'hFF);
    // Group B: ordered-set header, in_k ignored mid-block, next block header at bit offset 2.
    add_vec(1, 1, 8'h00, 1, 0, 0, 8'h00);
    for (int i = 1; i < 16; i++) add_vec(0, 1, 8'h00, logic'(i % 2), 0, 1, (i == 1) ? 8'h01 : 8'h00);
    add_vec(0, 1, 8'h00, 0, 0, 1, 8'h00);
    add_vec(0, 1, 8'h00, 1, 0, 1, 8'h08);
    add_vec(0, 1, 8'h00, 1, 0, 1, 8'h00);

    apply_reset();
    foreach (tbl[i]) begin
      if (tbl[i].rst) apply_reset();
      cycle(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].byp);
      check("tbl_out_valid", last_ov, tbl[i].exp_ov);
      check("tbl_out_data",  last_od, tbl[i].exp_od);
    end

    // Continuous flow: stalls of one cycle at fixed accepted-word counts, dense output.
    apply_reset();
    stall_q.delete();
    acc_cnt = 0;
    err_cnt = 0;
    gaps    = 0;
    seen    = 1'b0;
    for (int c = 0; c < 300 && acc_cnt < 220; c++) begin
      cycle(1'b1, 8'($urandom), 1'($urandom), 1'b0);
      if (last_ov === 1'b1) seen = 1'b1;
      else if (seen) gaps++;
    end
    check("cont_accepted", acc_cnt, 220);
    check("cont_stall_count", stall_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check("cont_stall_at", (i < stall_q.size()) ? stall_q[i] : -1, exp_stall[i]);
    check("cont_out_gaps", gaps, 0);
    check("cont_blk_err", err_cnt, 0);

    // Underrun at word_idx 7 for three cycles, then resume without losing bits.
    apply_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom), 1'($urandom), 1'b0);
    check("udr_word_idx", gb.word_idx, 7);
    err_cnt = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("udr_pulses", err_cnt, 3);
    for (int i = 0; i < 25; i++) cycle(1'b1, 8'($urandom), 1'($urandom), 1'b0);
    check("udr_no_extra", err_cnt, 3);

    // Bypass entry at word_idx 5, pass-through, then exit with a fresh header.
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    err_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      cycle(1'b1, d, 1'b0, 1'b1);
      if (i == 0) check("byp_chg_out_valid", last_ov, 0);
      else check("byp_pass_data", last_od, d);
    end
    check("byp_enter_err", err_cnt, 1);
    err_cnt = 0;
    seen    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'h00, 1'b1, 1'b0);
      if (last_ov === 1'b1 && !seen) begin
        seen = 1'b1;
        check("byp_exit_hdr", last_od, 8'h01);
      end
    end
    check("byp_exit_seen", seen, 1);
    check("byp_exit_err", err_cnt, 0);

    // Reset in the middle of a block; the next accepted word starts a new block.
    apply_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    check("pre_rst_word_idx", gb.word_idx, 9);
    apply_reset();
    cycle(1'b1, 8'h00, 1'b1, 1'b0);
    check("post_rst_first_valid", last_ov, 0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    check("post_rst_valid", last_ov, 1);
    check("post_rst_hdr", last_od, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
